slc3_datapath_gen: RTL

Parametrised next-generation SLC-3 datapath. Extends the PC/MAR/MDR/IR + bus datapath with an 8-entry register file, ALU, address adder, PC/MAR source muxes, NZP condition codes and branch-enable register. Driven cycle by cycle by the ISDU control FSM; memory data arrives through MDR_In.

---
 rtl/slc3_pkg.sv | 42 ++++
 rtl/slc3_reg_file.sv | 37 +++
 rtl/slc3_datapath_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types and helpers for the SLC-3 datapath.
//   alu_op_t   - ALUK encodings
//   pcmux_t    - PCMUX encodings
//   addr2mux_t - ADDR2MUX encodings
//   sext()     - sign-extend bits [msb:0] of a value to SEXT_MAX_W bits;
//                callers size-cast the result down to their own WIDTH.
package slc3_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_IDX_W  = 3;
    localparam int SEXT_MAX_W = 64;   // widest datapath sext() can serve

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PCMUX_INC  = 2'b00,
        PCMUX_BUS  = 2'b01,
        PCMUX_ADDR = 2'b10,
        PCMUX_HOLD = 2'b11
    } pcmux_t;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'b00,
        ADDR2_OFF6  = 2'b01,
        ADDR2_OFF9  = 2'b10,
        ADDR2_OFF11 = 2'b11
    } addr2mux_t;

    // keep has bits [msb:0] set; everything above msb is replaced by value[msb].
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] value,
                                                    input logic [5:0]            msb);
        logic [SEXT_MAX_W-1:0] keep;
        keep = {SEXT_MAX_W{1'b1}} >> (6'd63 - msb);
        return value[msb] ? (value | ~keep) : (value & keep);
    endfunction

endpackage

// File: rtl/slc3_reg_file.sv
// slc3_reg_file: NUM_REGS x WIDTH general-purpose register file.
//   clk, rst         - clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata - synchronous write port
//   raddr_a/rdata_a  - combinational read port A (SR1)
//   raddr_b/rdata_b  - combinational read port B (SR2)
// Reads see the pre-edge contents, so a read of the register being written
// in the same cycle returns the old value.
module slc3_reg_file
    import slc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/slc3_datapath_gen.sv
// slc3_datapath_gen: parametrised SLC-3 datapath (PC/MAR/MDR/IR, bus,
// register file, ALU, address adder, NZP and BEN), sequenced by the ISDU.
//   Clk, Reset                        - clock, asynchronous active-high reset
//   GatePC/GateMDR/GateALU/GateMARMUX - bus source enables
//   LD_*                              - register load enables
//   PCMUX, DRMUX, SR1MUX, SR2MUX,
//   ADDR1MUX, ADDR2MUX, ALUK          - datapath mux / ALU selects
//   MIO_EN, MDR_In                    - MDR source select and memory read data
//   MAR, MDR, IR, PC, NZP, BEN        - register contents
// Optional: define SLC3_BUS_CHECK_EN to add BUS_ERR, a sticky flag set on the
// edge after any cycle with two or more gates high (cleared only by Reset).
module slc3_datapath_gen
    import slc3_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = WIDTH'(16'h3000),
    parameter logic [2:0]       CC_RESET = 3'b010
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_IR,
    input  logic             LD_PC,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [1:0]       PCMUX,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             ADDR1MUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             MIO_EN,
    input  logic [WIDTH-1:0] MDR_In,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
`ifdef SLC3_BUS_CHECK_EN
    output logic             BUS_ERR,
`endif
    output logic [2:0]       NZP,
    output logic             BEN
);

    logic [15:0]          ir16;
    logic [REG_IDX_W-1:0] sr1_idx, dr_idx;
    logic [WIDTH-1:0]     sr1_data, sr2_data, alu_b, alu_out;
    logic [WIDTH-1:0]     imm5, off6, off9, off11;
    logic [WIDTH-1:0]     addr1, addr2, addr_sum;
    logic [WIDTH-1:0]     bus, pc_next;
    logic [2:0]           cc_from_bus;

    // Decode only looks at the low 16 bits, whatever WIDTH is.
    assign ir16    = IR[15:0];
    assign sr1_idx = SR1MUX ? ir16[8:6] : ir16[11:9];
    assign dr_idx  = DRMUX ? REG_IDX_W'(NUM_REGS - 1) : ir16[11:9];

    assign imm5  = WIDTH'(sext(SEXT_MAX_W'(ir16), 6'd4));
    assign off6  = WIDTH'(sext(SEXT_MAX_W'(ir16), 6'd5));
    assign off9  = WIDTH'(sext(SEXT_MAX_W'(ir16), 6'd8));
    assign off11 = WIDTH'(sext(SEXT_MAX_W'(ir16), 6'd10));

    slc3_reg_file #(.WIDTH(WIDTH)) u_reg_file (
        .clk     (Clk),
        .rst     (Reset),
        .we      (LD_REG),
        .waddr   (dr_idx),
        .wdata   (bus),
        .raddr_a (sr1_idx),
        .rdata_a (sr1_data),
        .raddr_b (ir16[2:0]),
        .rdata_b (sr2_data)
    );

    assign alu_b = SR2MUX ? imm5 : sr2_data;

    always_comb begin
        alu_out = '0;
        case (alu_op_t'(ALUK))
            ALU_ADD:  alu_out = sr1_data + alu_b;
            ALU_AND:  alu_out = sr1_data & alu_b;
            ALU_NOT:  alu_out = ~sr1_data;
            ALU_PASS: alu_out = sr1_data;
            default:  alu_out = '0;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_data : PC;

    always_comb begin
        addr2 = '0;
        case (addr2mux_t'(ADDR2MUX))
            ADDR2_ZERO:  addr2 = '0;
            ADDR2_OFF6:  addr2 = off6;
            ADDR2_OFF9:  addr2 = off9;
            ADDR2_OFF11: addr2 = off11;
            default:     addr2 = '0;
        endcase
    end

    assign addr_sum = addr1 + addr2;

    // Fixed priority keeps the bus defined even if the FSM ever overlaps gates.
    always_comb begin
        if (GatePC)          bus = PC;
        else if (GateMDR)    bus = MDR;
        else if (GateALU)    bus = alu_out;
        else if (GateMARMUX) bus = addr_sum;
        else                 bus = '0;
    end

    always_comb begin
        pc_next = PC;
        case (pcmux_t'(PCMUX))
            PCMUX_INC:  pc_next = PC + WIDTH'(1);
            PCMUX_BUS:  pc_next = bus;
            PCMUX_ADDR: pc_next = addr_sum;
            PCMUX_HOLD: pc_next = PC;
            default:    pc_next = PC;
        endcase
    end

    assign cc_from_bus = bus[WIDTH-1]  ? 3'b100 :
                         (bus == '0)   ? 3'b010 : 3'b001;

    // BEN uses the registered IR and NZP, so same-cycle LD_IR / LD_CC
    // do not feed into it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC  <= PC_RESET;
            MAR <= '0;
            MDR <= '0;
            IR  <= '0;
            NZP <= CC_RESET;
            BEN <= 1'b0;
        end else begin
            if (LD_MAR) MAR <= bus;
            if (LD_MDR) MDR <= MIO_EN ? MDR_In : bus;
            if (LD_IR)  IR  <= bus;
            if (LD_PC)  PC  <= pc_next;
            if (LD_CC)  NZP <= cc_from_bus;
            if (LD_BEN) BEN <= |(ir16[11:9] & NZP);
        end
    end

`ifdef SLC3_BUS_CHECK_EN
    logic multi_gate;
    assign multi_gate = ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BUS_ERR <= 1'b0;
        end else if (multi_gate) begin
            BUS_ERR <= 1'b1;
            $error("slc3_datapath_gen: more than one bus gate enabled");
        end
    end
`endif

endmodule
